// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Constants and types shared by the UART transmit and receive paths.
//   UART_BIT_COUNT   : clk cycles per bit (100 MHz / 9600, rounded down)
//   UART_FRAME_WIDTH : data bits per frame (8N1 framing)
//   rx_state_t       : receiver state encoding
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_BIT_COUNT   = 10416;
    localparam int UART_FRAME_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/rx_baud_counter.sv
// -----------------------------------------------------------------------------
// rx_baud_counter
// Bit timer for the UART receiver. Counts while cnt_en is high and wraps at the
// selected terminal count (HALF_COUNT-1 or BIT_COUNT-1). tick is high for the
// cycle in which the count sits on its terminal value.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   cnt_en   in  count enable; counter and tick clear while low
//   half_sel in  1: half-bit terminal count, 0: full-bit terminal count
//   tick     out registered sample strobe
// -----------------------------------------------------------------------------
module rx_baud_counter
    import uart_pkg::*;
#(
    parameter int BIT_COUNT  = UART_BIT_COUNT,
    parameter int HALF_COUNT = BIT_COUNT / 2,
    parameter int TIMER_W    = $clog2(BIT_COUNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    input  logic half_sel,
    output logic tick
);

    // BIT_COUNT-1 < 2**$clog2(BIT_COUNT), so the cast never drops a set bit.
    localparam logic [TIMER_W-1:0] FULL_TERM = TIMER_W'(BIT_COUNT - 1);
    localparam logic [TIMER_W-1:0] HALF_TERM = TIMER_W'(HALF_COUNT - 1);

    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] cnt_nxt;
    logic [TIMER_W-1:0] term;

    always_comb begin
        term    = half_sel ? HALF_TERM : FULL_TERM;
        cnt_nxt = (cnt == term) ? '0 : cnt + TIMER_W'(1);
    end

    // tick is computed from the next count, so the registered strobe lines up
    // with the cycle where cnt equals the terminal value.
    always_ff @(posedge clk) begin
        if (rst || !cnt_en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == term);
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// 8N1 UART receiver, LSB first, idle-high line. Synchronises rx_in, qualifies
// the start bit at mid-bit, samples data and stop bits at mid-bit and presents
// the byte with a one-cycle valid strobe. A low stop bit raises frame_err and
// the receiver waits for the line to return high before looking for a start.
// Ports:
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   rx_in     in  asynchronous serial input, idle high
//   rx_data   out last correctly framed byte, held until the next good frame
//   rx_valid  out one-cycle pulse, rx_data is new this cycle
//   frame_err out one-cycle pulse, stop bit sampled low
//   rx_busy   out high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int BIT_COUNT   = UART_BIT_COUNT,
    parameter int FRAME_WIDTH = UART_FRAME_WIDTH,
    parameter int HALF_COUNT  = BIT_COUNT / 2,
    parameter int TIMER_W     = $clog2(BIT_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    output logic [FRAME_WIDTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic                   rx_busy
);

    localparam int IDX_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WIDTH - 1);

    rx_state_t              state;
    logic                   rx_sync_p0;
    logic                   rx_s;
    logic [FRAME_WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0]       bit_idx;
    logic                   cnt_en;
    logic                   half_sel;
    logic                   tick;

    // Stage p0 -> rx_s: two-flop synchroniser, reset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_in;
            rx_s       <= rx_sync_p0;
        end
    end

    // The timer runs only in the timed states. Every transition out of a timed
    // state happens on its tick, where the counter wraps to 0 anyway, so the
    // next state always starts from a cleared timer.
    assign cnt_en   = (state == START) || (state == DATA) || (state == STOP);
    assign half_sel = (state == START);

    rx_baud_counter #(
        .BIT_COUNT (BIT_COUNT),
        .HALF_COUNT(HALF_COUNT),
        .TIMER_W   (TIMER_W)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .cnt_en  (cnt_en),
        .half_sel(half_sel),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    // Only the mid-start sample decides; a high seen earlier
                    // is ignored, a high at the sample is a glitch.
                    if (tick) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {rx_s, shift_reg[FRAME_WIDTH-1:1]};
                        bit_idx   <= bit_idx + IDX_W'(1);
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    // Leaving at mid-stop gives half a bit of slack to catch
                    // the next start edge on back-to-back frames.
                    if (tick) begin
                        if (rx_s) begin
                            rx_data  <= shift_reg;
                            rx_valid <= 1'b1;
                            state    <= IDLE;
                            rx_busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // A held-low line must not be mistaken for a new start bit.
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receiver: the receive-side counterpart of the existing transmit path. Same 8N1 framing, LSB first, idle-high line.
- Synchronises the asynchronous rx line, qualifies the start bit at mid-bit, samples each data bit and the stop bit at mid-bit, then presents the byte with a one-cycle valid strobe.
- Sits between the board RX pin and the host-side consumer logic. Uses the same bit-period constant as the transmitter, so both ends agree on baud.

Parameters:
- BIT_COUNT, 10416, clk cycles per bit (100 MHz / 9600, rounded down).
- FRAME_WIDTH, 8, data bits per frame.
- HALF_COUNT, BIT_COUNT/2 (5208), cycles from start-bit falling edge to the mid-start sample point.
- TIMER_W, $clog2(BIT_COUNT), width of the bit timer.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-high.
- rx_in  in  1  asynchronous serial input, idle high.
- rx_data  out  FRAME_WIDTH  last correctly framed byte; holds until the next good frame.
- rx_valid  out  1  one-cycle pulse; rx_data is new this cycle.
- frame_err  out  1  one-cycle pulse; stop bit sampled low.
- rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: sync flops = 1, state = IDLE, timer = 0, bit index = 0, shift register = 0, rx_data = 0, rx_valid = 0, frame_err = 0, rx_busy = 0. Reset mid-frame aborts the frame with no strobe; the partial byte is discarded.
- Synchroniser: two flops on rx_in, both reset to 1. All decisions use the second flop (rx_s), which is 2 cycles behind the pin.
- Bit timer:
  - Clears on every state transition.
  - Otherwise increments each cycle, and in DATA/STOP wraps to 0 at BIT_COUNT-1.
  - A sample event ("tick") occurs when the timer equals the state's terminal count: HALF_COUNT-1 in START, BIT_COUNT-1 in DATA/STOP.
- IDLE: when rx_s = 0, go to START.
- START:
  - At tick, if rx_s = 0, go to DATA with bit index = 0.
  - At tick, if rx_s = 1, the low was a glitch: return to IDLE with no strobe.
  - A high on rx_s before the tick is ignored; only the tick sample decides.
- DATA:
  - At each tick, shift rx_s in at the MSB and shift right, so the first received bit ends up in bit 0. Increment bit index.
  - When the tick for bit index FRAME_WIDTH-1 occurs, go to STOP.
- STOP (tick at mid-stop):
  - If rx_s = 1: rx_data <= shift register, rx_valid = 1 for exactly the next cycle, go to IDLE.
  - If rx_s = 0: frame_err = 1 for one cycle, rx_data unchanged, go to BREAK.
- BREAK: wait until rx_s = 1, then go to IDLE. This prevents a held-low line (break condition) from being taken as a new start bit.
- Latency: the strobe is registered on the cycle after the stop-bit tick.
- Back-to-back frames: returning to IDLE at mid-stop means a start edge arriving half a bit later is caught with no dead time.
- Exclusivity: rx_valid and frame_err never assert together. rx_data changes only on the cycle rx_valid asserts.
- Width rule: the timer compare uses BIT_COUNT-1 at TIMER_W bits; it must not truncate for any BIT_COUNT >= 4.

Decomposition:
- Shared package uart_pkg:
  - BIT_COUNT and FRAME_WIDTH defaults, common to TX and RX.
  - State enumeration {IDLE, START, DATA, STOP, BREAK}, 3-bit encoding.
- One sub-module: rx_baud_counter.
  - Inputs: cnt_en, a half/full-period select, clk, rst.
  - Output: registered tick.
  - Counter clears whenever cnt_en is low.
- The FSM, synchroniser and shift register stay in uart_rx_frame.

Test Plan (sim overrides BIT_COUNT=16, HALF_COUNT=8):
- Reset, rx_in held 1 for 100 cycles -> rx_busy=0, rx_valid=0, rx_data=0x00.
- Send frame 0xA5, 16 cycles per bit -> exactly one rx_valid pulse, rx_data=0xA5, frame_err=0; rx_valid occurs 1 cycle after the mid-stop sample.
- Glitch: rx_in low for 4 cycles, then high -> returns to IDLE, no rx_valid, no frame_err. A following 0x3C frame is received correctly.
- Stop bit forced 0 on frame 0x55, line then held low 40 cycles -> one frame_err pulse, rx_data unchanged, no strobe during the low hold. After the line rises, frame 0x0F gives rx_valid with 0x0F.
- Back-to-back frames 0x00, 0xFF, 0x81 with single stop bits -> three rx_valid pulses carrying 0x00, 0xFF, 0x81 in order.
- Assert rst during bit 4 of 0x96 -> outputs return to reset values, no strobe. The next clean 0x96 frame is received.
